// File: rtl/uart_tx_fifo_module.sv
// uart_tx_fifo_module
// 8N1 UART transmitter, LSB first, fed by a small circular write FIFO.
// The producer writes one byte per cycle through tx_wr / tx_data. The FSM
// pulls bytes from the FIFO and serialises them on TXD. Frames run
// back-to-back while bytes are queued. TXD comes straight from a flop.

module uart_tx_fifo_module #(
  parameter int BAUD_DIV = 5208,  // clock cycles per bit, 4..65535
  parameter int ADDR_W   = 4      // FIFO depth = 2**ADDR_W
) (
  input  logic              CLK_50M,
  input  logic              RST_N,
  input  logic [7:0]        tx_data,
  input  logic              tx_wr,
  output logic              tx_full,
  output logic              tx_empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_overflow,
  output logic              TXD
);

  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [15:0]     BAUD_LAST  = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // FSM / shifter state
  state_e            state_q,   state_d;
  logic [15:0]       baud_q,    baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q,   shift_d;
  logic              txd_q,     txd_d;

  // FIFO state
  logic [ADDR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [ADDR_W:0]   count_q,   count_d;
  logic [7:0]        mem [DEPTH];

  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_accept;
  logic              pop;
  logic              bit_end;
  logic [7:0]        head_data;

  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  // The full test uses the count before any same-cycle pop, so a write
  // into a full FIFO is dropped even when a byte leaves on that edge.
  assign wr_accept  = tx_wr & ~fifo_full;
  assign head_data  = mem[rd_ptr_q];
  assign bit_end    = (baud_q == BAUD_LAST);

  // FIFO pointer and occupancy update
  // NOTE: every signal written in an always_comb gets a default on the
  // first lines, so no path can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)       rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write port
  // NOTE: the data array has no reset. Validity is carried by the pointers
  // and count alone, which keeps the array free to map onto RAM.
  always_ff @(posedge CLK_50M) begin
    if (wr_accept) mem[wr_ptr_q] <= tx_data;
  end

  // Transmit FSM: next state, baud/bit counters, shifter and FIFO pop
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    // The baud counter free-runs 0..BAUD_DIV-1 in every state except IDLE.
    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head_data;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          // Load the next byte on the same edge that ends the stop bit,
          // so a queued stream has no idle gap between frames.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head_data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serial line value for the next cycle, decoded from the next state so
  // the line can be registered without adding a cycle of latency.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and discards queued bytes
  // NOTE: flops take non-blocking assignments so all of them update from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign TXD         = txd_q;
  assign tx_full     = fifo_full;
  assign tx_empty    = fifo_empty;
  assign fifo_count  = count_q;
  assign tx_busy     = (state_q != IDLE);
  // High for the last cycle of every stop bit.
  assign tx_done     = (state_q == STOP) && bit_end;
  // High in the cycle a write is presented to a full FIFO.
  assign tx_overflow = tx_wr & fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo_module.sv
// Testbench for uart_tx_fifo_module (BAUD_DIV=8, 16-entry FIFO).
// A queue-plus-frame-position model predicts every output each cycle.
// A serial decoder on TXD and literal expectations pin the model.

module tb_uart_tx_fifo_module;

  localparam int B     = 8;       // cycles per bit
  localparam int FL    = 10 * B;  // cycles per frame
  localparam int DEPTH = 16;

  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_wr   = 1'b0;
  logic       tx_full, tx_empty, tx_busy, tx_done, tx_overflow, txd;
  logic [4:0] fifo_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  uart_tx_fifo_module #(.BAUD_DIV(B), .ADDR_W(4)) dut (
    .CLK_50M    (clk_50m),
    .RST_N      (rst_n),
    .tx_data    (tx_data),
    .tx_wr      (tx_wr),
    .tx_full    (tx_full),
    .tx_empty   (tx_empty),
    .fifo_count (fifo_count),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_overflow(tx_overflow),
    .TXD        (txd)
  );

  always #5 clk_50m = ~clk_50m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_q: bytes waiting; m_t: position within current frame (-1 = idle)
  logic [7:0] m_q[$];
  logic [7:0] sent_q[$];
  int         m_t   = -1;
  logic [7:0] m_cur = 8'h00;

  initial forever begin
    @(posedge clk_50m or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_t = -1;
    end else begin
      bit acc, pp;
      cyc++;
      acc = tx_wr && (m_q.size() < DEPTH);
      pp  = ((m_t < 0) || (m_t == FL - 1)) && (m_q.size() > 0);
      if (pp) begin
        m_cur = m_q.pop_front();
        m_t   = 0;
      end else if (m_t == FL - 1) begin
        m_t = -1;
      end else if (m_t >= 0) begin
        m_t++;
      end
      if (acc) begin
        m_q.push_back(tx_data);
        sent_q.push_back(tx_data);
      end
    end
  end

  // Per-cycle comparison against the model, half a cycle after each edge
  int   e_bit;
  logic e_txd;
  initial forever begin
    @(negedge clk_50m);
    e_bit = (m_t < 0) ? -1 : m_t / B;
    if (m_t < 0)         e_txd = 1'b1;
    else if (e_bit == 0) e_txd = 1'b0;
    else if (e_bit == 9) e_txd = 1'b1;
    else                 e_txd = m_cur[e_bit-1];
    check("txd",      txd,         e_txd);
    check("busy",     tx_busy,     m_t >= 0);
    check("done",     tx_done,     m_t == FL - 1);
    check("overflow", tx_overflow, tx_wr && (m_q.size() == DEPTH));
    check("count",    fifo_count,  m_q.size());
    check("empty",    tx_empty,    m_q.size() == 0);
    check("full",     tx_full,     m_q.size() == DEPTH);
  end

  // ---------------- monitors ----------------
  int done_cyc[$];
  int busy_cnt = 0;
  int max_cnt  = 0;
  initial forever begin
    @(negedge clk_50m);
    if (tx_done) done_cyc.push_back(cyc);
    if (tx_busy) busy_cnt++;
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
  end

  int rst_epoch = 0;
  initial forever begin
    @(negedge rst_n);
    rst_epoch++;
  end

  // Serial decoder: samples each bit in its middle, drops frames cut by reset
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx[$];
  initial forever begin
    @(negedge clk_50m);
    if (rst_n && txd === 1'b0) begin
      int         ep;
      logic [7:0] b;
      ep = rst_epoch;
      repeat (B + B / 2) @(negedge clk_50m);
      for (int i = 0; i < 8; i++) begin
        b[i] = txd;
        if (i < 7) repeat (B) @(negedge clk_50m);
      end
      repeat (B) @(negedge clk_50m);
      if (ep == rst_epoch) begin
        check("rx_stop_bit", txd, 1'b1);
        rx_q.push_back(b);
      end
      repeat (B / 2 - 1) @(negedge clk_50m);
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((tx_busy || !tx_empty) && n < budget) begin
      @(negedge clk_50m);
      n++;
    end
    check("drain_timeout", tx_busy || !tx_empty, 1'b0);
  endtask

  task automatic check_rx(input string name);
    check({name, "_len"}, rx_q.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++)
      check(name, rx_q[i], exp_rx[i]);
  endtask

  // Global time limit
  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  logic [9:0] frame;
  logic [7:0] d17[18];

  initial begin
    repeat (3) @(posedge clk_50m);
    #3 rst_n = 1'b1;
    @(negedge clk_50m);
    check("rst_txd",   txd,         1'b1);
    check("rst_busy",  tx_busy,     1'b0);
    check("rst_count", fifo_count,  5'd0);
    check("rst_empty", tx_empty,    1'b1);
    check("rst_full",  tx_full,     1'b0);
    check("rst_done",  tx_done,     1'b0);
    check("rst_ovf",   tx_overflow, 1'b0);

    // 1) single byte 0x35: exact waveform, done in the last stop cycle
    rx_q.delete(); done_cyc.delete(); busy_cnt = 0;
    @(posedge clk_50m); #1 tx_data = 8'h35; tx_wr = 1'b1;
    @(posedge clk_50m); #1 tx_wr = 1'b0; tx_data = 8'hFF;
    @(negedge clk_50m);
    check("t1_count_after_write", fifo_count, 5'd1);
    check("t1_txd_before_pop",    txd,        1'b1);
    frame = {1'b1, 8'h35, 1'b0};
    for (int k = 0; k < FL; k++) begin
      @(negedge clk_50m);
      check("t1_txd",  txd,     frame[k/B]);
      check("t1_done", tx_done, k == FL - 1);
    end
    @(negedge clk_50m);
    check("t1_busy_after",  tx_busy,         1'b0);
    check("t1_empty_after", tx_empty,        1'b1);
    check("t1_busy_cycles", busy_cnt,        FL);
    check("t1_done_pulses", done_cyc.size(), 1);
    exp_rx.delete(); exp_rx.push_back(8'h35);
    check_rx("t1_rx");

    // 2) burst of three: back-to-back frames
    rx_q.delete(); done_cyc.delete(); busy_cnt = 0; max_cnt = 0;
    @(posedge clk_50m); #1 tx_data = 8'h31; tx_wr = 1'b1;
    @(posedge clk_50m); #1 tx_data = 8'h32;
    @(posedge clk_50m); #1 tx_data = 8'h33;
    @(posedge clk_50m); #1 tx_wr = 1'b0;
    wait_drain(4 * FL);
    check("t2_peak_count",  max_cnt,         2);
    check("t2_busy_cycles", busy_cnt,        3 * FL);
    check("t2_done_pulses", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check("t2_done_gap1", done_cyc[1] - done_cyc[0], FL);
      check("t2_done_gap2", done_cyc[2] - done_cyc[1], FL);
    end
    exp_rx.delete();
    exp_rx.push_back(8'h31); exp_rx.push_back(8'h32); exp_rx.push_back(8'h33);
    check_rx("t2_rx");

    // 3) 17 writes fill shifter + FIFO, 18th overflows;
    // 4) then a write coincident with the pop at the end of frame 1
    rx_q.delete(); exp_rx.delete();
    for (int i = 0; i < 18; i++) d17[i] = 8'($urandom);
    for (int i = 0; i < 18; i++) begin
      @(posedge clk_50m); #1 tx_data = d17[i]; tx_wr = 1'b1;
      if (i < 17) exp_rx.push_back(d17[i]);
      if (i == 17) begin
        @(negedge clk_50m);
        check("t3_full",     tx_full,     1'b1);
        check("t3_overflow", tx_overflow, 1'b1);
        check("t3_count16",  fifo_count,  5'd16);
      end
    end
    @(posedge clk_50m); #1 tx_wr = 1'b0; tx_data = 8'($urandom);
    @(negedge clk_50m);
    check("t3_count_held", fifo_count,  5'd16);
    check("t3_ovf_clear",  tx_overflow, 1'b0);
    repeat (63) @(posedge clk_50m);
    #1 tx_data = 8'hEE; tx_wr = 1'b1;
    @(negedge clk_50m);
    check("t4_done",     tx_done,     1'b1);
    check("t4_overflow", tx_overflow, 1'b1);
    check("t4_count16",  fifo_count,  5'd16);
    @(posedge clk_50m); #1 tx_wr = 1'b0;
    @(negedge clk_50m);
    check("t4_count15",  fifo_count,  5'd15);
    check("t4_ovf_gone", tx_overflow, 1'b0);
    wait_drain(20 * FL);
    check_rx("t3_rx");

    // 5) pointer wrap: 40 bytes in groups of 10
    for (int g = 0; g < 4; g++) begin
      rx_q.delete(); exp_rx.delete();
      for (int i = 0; i < 10; i++) begin
        @(posedge clk_50m); #1 tx_data = 8'(g * 10 + i); tx_wr = 1'b1;
        exp_rx.push_back(8'(g * 10 + i));
      end
      @(posedge clk_50m); #1 tx_wr = 1'b0;
      wait_drain(12 * FL);
      check("t5_count_zero", fifo_count, 5'd0);
      check_rx("t5_rx");
    end

    // Random traffic, heavy enough to hit full and overflow
    rx_q.delete(); sent_q.delete();
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk_50m); #1;
      tx_wr   = ($urandom_range(0, 9) == 0);
      tx_data = 8'($urandom);
    end
    @(posedge clk_50m); #1 tx_wr = 1'b0;
    wait_drain(20 * FL);
    exp_rx = sent_q;
    check_rx("rand_rx");

    // 6) reset mid-DATA of 0xA5 with 4 bytes queued
    rx_q.delete();
    @(posedge clk_50m); #1 tx_data = 8'hA5; tx_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_50m); #1 tx_data = 8'($urandom);
    end
    @(posedge clk_50m); #1 tx_wr = 1'b0;
    @(negedge clk_50m);
    check("t6_count4", fifo_count, 5'd4);
    repeat (17) @(posedge clk_50m);
    #3;
    check("t6_txd_low_before", txd, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_txd_async",  txd,        1'b1);
    check("t6_busy_rst",   tx_busy,    1'b0);
    check("t6_count_rst",  fifo_count, 5'd0);
    check("t6_empty_rst",  tx_empty,   1'b1);
    repeat (2) @(posedge clk_50m);
    #3 rst_n = 1'b1;
    busy_cnt = 0;
    repeat (300) @(negedge clk_50m);
    check("t6_no_busy",   busy_cnt,    0);
    check("t6_no_frames", rx_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
